// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_detect_pkg;

   localparam int unsigned DEFAULT_PLEN = 4;
   localparam logic [DEFAULT_PLEN-1:0] DEFAULT_PATTERN = 4'b1101;

   // Ceiling log2, used to size the fill counter (clog2(PLEN+1) bits).
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = value - 1;
      while (x != 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_hist.sv
// History shift chain with valid-bit fill counter; a multi-bit D flip-flop
// stage that also exposes its would-be next state for the comparator.
module seq_hist
   import seq_detect_pkg::*;
#(
   parameter  int unsigned PLEN = DEFAULT_PLEN,
   localparam int unsigned FW   = clog2(PLEN + 1)
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            en,
   input  logic            din,
   input  logic            flush,
   output logic [PLEN-1:0] hist,
   output logic [FW-1:0]   fill,
   output logic [PLEN-1:0] hist_nxt_c,
   output logic [FW-1:0]   fill_nxt_c
);

   logic [PLEN-1:0] hist_q, hist_d;
   logic [FW-1:0]   fill_q, fill_d;

   // Candidate window/fill if the current bit is consumed; flush discards it.
   always_comb begin
      hist_nxt_c = {hist_q[PLEN-2:0], din};
      fill_nxt_c = (fill_q == FW'(PLEN)) ? fill_q : fill_q + FW'(1);
      hist_d     = hist_q;
      fill_d     = fill_q;
      if (en) begin
         if (flush) begin
            hist_d = '0;
            fill_d = '0;
         end else begin
            hist_d = hist_nxt_c;
            fill_d = fill_nxt_c;
         end
      end
   end

   // State register with synchronous clear.
   always_ff @(posedge clk) begin
      if (clr) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

   assign hist = hist_q;
   assign fill = fill_q;

endmodule

// File: rtl/seq_detect.sv
// Serial pattern detector: compares the bit history against PATTERN and
// reports matches with a one-cycle hit pulse and a saturating counter.
module seq_detect
   import seq_detect_pkg::*;
#(
   parameter  int unsigned     PLEN    = DEFAULT_PLEN,
   parameter  logic [PLEN-1:0] PATTERN = PLEN'(DEFAULT_PATTERN),
   parameter  bit              OVERLAP = 1'b1,
   parameter  int unsigned     CNT_W   = 8,
   localparam int unsigned     FW      = clog2(PLEN + 1)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic             hit,
   output logic [CNT_W-1:0] cnt,
   output logic [PLEN-1:0]  hist,
   output logic [FW-1:0]    fill
);

   logic [PLEN-1:0]  hist_nxt_c;
   logic [FW-1:0]    fill_nxt_c;
   logic             match_c;
   logic             flush_c;
   logic             hit_q, hit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   seq_hist #(
      .PLEN (PLEN)
   ) u_hist (
      .clk        (clk),
      .clr        (clr),
      .en         (en),
      .din        (din),
      .flush      (flush_c),
      .hist       (hist),
      .fill       (fill),
      .hist_nxt_c (hist_nxt_c),
      .fill_nxt_c (fill_nxt_c)
   );

   // A match needs a full window of fresh bits equal to the pattern.
   always_comb begin
      match_c = en && (fill_nxt_c == FW'(PLEN)) && (hist_nxt_c == PATTERN);
      flush_c = match_c && !OVERLAP;
   end

   // Hit pulse and saturating match counter next-state.
   always_comb begin
      hit_d = 1'b0;
      cnt_d = cnt_q;
      if (match_c) begin
         hit_d = 1'b1;
         if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Output registers with synchronous clear.
   always_ff @(posedge clk) begin
      if (clr) begin
         hit_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         hit_q <= hit_d;
         cnt_q <= cnt_d;
      end
   end

   assign hit = hit_q;
   assign cnt = cnt_q;

endmodule

// File: doc/seq_detect.md
Name: seq_detect

Overview:
Serial pattern detector that sits directly downstream of the D flip-flop stage and consumes its registered q bit stream, one bit per qualified clock.
- Shifts qualified bits into a history window and compares the window against a fixed pattern.
- On a match, emits a one-cycle hit pulse and increments a saturating match counter.
- Used in the lab datapath as the consumer of flip-flop and shift-chain outputs. Supports overlapping and non-overlapping detection.

Parameters:
PLEN, 4, pattern length in bits (2..16).
PATTERN, 4'b1101, pattern to detect, PLEN bits wide, MSB = oldest bit received.
OVERLAP, 1, 1 = matches may share bits; 0 = history is discarded after each match.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  rising-edge clock, single clock domain.
clr  input  1  synchronous, active-high reset; sampled only on the rising edge of clk.
en  input  1  bit-valid; din is consumed only on edges where en=1.
din  input  1  serial data bit (the q output of the upstream flip-flop).
hit  output  1  registered one-cycle pulse, =1 on the edge that consumed the completing bit.
cnt  output  CNT_W  number of matches since clr; saturates at all-ones.
hist  output  PLEN  current history window, hist[0] = newest bit.
fill  output  clog2(PLEN+1)  number of valid bits in hist (0..PLEN).

Behaviour:
- Reset: on a rising edge with clr=1, hit=0, cnt=0, hist=0, fill=0. clr has priority over en and din.
- Idle: on an edge with clr=0 and en=0, hist, fill and cnt hold; hit=0. hit never stays high for two edges unless two consecutive qualified bits each complete a match.
- Qualified bit: on an edge with clr=0 and en=1:
  - nh = {hist[PLEN-2:0], din}.
  - nf = min(fill+1, PLEN).
  - match = (nf == PLEN) && (nh == PATTERN).
- Register updates on a qualified bit:
  - hist <= nh.
  - hit <= match.
  - cnt <= cnt+1 when match and cnt != all-ones; otherwise cnt holds.
  - fill <= nf when OVERLAP=1 or no match.
  - fill <= 0 and hist <= 0 when OVERLAP=0 and match.
- Latency: hit and cnt reflect the completing bit one edge after it is presented, i.e. on the same edge that consumes it. There is no combinational path from din to any output.
- A match is never reported until PLEN bits have been received since clr or since the last non-overlapping match. For example, with PATTERN=0000, zeros already sitting in hist after reset do not count.
- Boundary cases:
  - cnt at all-ones plus a match: hit=1, cnt stays at all-ones.
  - fill saturates at PLEN.
  - clr in mid-pattern: all partial progress is lost, and the next match needs PLEN fresh bits.
- All outputs are direct register outputs.

Decomposition:
- Shared package: DEFAULT_PATTERN (4'b1101), DEFAULT_PLEN (4), and a clog2 constant function for the fill width.
- One sub-module: seq_hist. It holds the PLEN-bit shift chain and the fill counter, with inputs clk, clr, en, din and flush (driven by non-overlapping matches). It is the multi-bit extension of the team's D flip-flop.
- Compare, hit and counter logic stays in seq_detect.

Test Plan:
- Reset: drive clr=1 for 2 edges with random din/en -> hit=0, cnt=0, hist=0000, fill=0.
- OVERLAP=1, PATTERN=1101, stream 1,1,0,1,1,0,1 with en=1 every edge -> hit pulses on the edges consuming bits 4 and 7; final cnt=2.
- OVERLAP=0, same stream -> hit only on bit 4; fill returns to 0 after it; final cnt=1, fill=3.
- en gaps: same stream with en=0 on alternate edges and din toggled during the gaps -> identical hits (2) and cnt; hist/fill frozen on en=0 edges.
- Mid-pattern clr: bits 1,1,0, then clr=1 for one edge, then bits 1,1,1,0,1 -> exactly one hit, on the final bit; cnt=1.
- Saturation: CNT_W=2, OVERLAP=1, five overlapping matches of 1101 (stream 1101101101101101) -> cnt sequence 1,2,3,3,3; hit pulses all five times.
